// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, instruction RAM address, and the IF/ID pipeline register. One-edge fetch latency.
// Backpressure: a stall holds the PC and IF/ID, a branch flushes IF/ID and redirects, and a PC past the end of the RAM halts fetching.
module fetch_stage #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc4,
    output logic              if_id_valid,
    output logic              fetch_halt,
    output logic [15:0]       fetch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] pc4_nxt;
    logic        valid_nxt;
    logic [15:0] count_nxt;

    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;
    logic        pc_in_range;
    logic        target_in_range;
    logic [15:0] count_inc;

    assign pc_plus4       = pc + 32'd4;
    assign target_aligned = branch_target & ~32'd3;

    // Range checks use the full 32-bit value so a wrapped or large PC never aliases into the RAM.
    assign pc_in_range     = (pc >> ADDR_W) == 32'd0;
    assign target_in_range = (target_aligned >> ADDR_W) == 32'd0;

    assign count_inc  = (fetch_count == 16'hFFFF) ? fetch_count : fetch_count + 16'd1;
    assign imem_addr  = pc[ADDR_W-1:0];
    assign fetch_halt = (state == HALT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
            fetch_count <= 16'h0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            if_id_instr <= instr_nxt;
            if_id_pc4   <= pc4_nxt;
            if_id_valid <= valid_nxt;
            fetch_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = if_id_instr;
        pc4_nxt   = if_id_pc4;
        valid_nxt = if_id_valid;
        count_nxt = fetch_count;

        case (state)
            RUN: begin
                if (branch_taken) begin
                    pc_nxt    = target_aligned;
                    instr_nxt = 32'h0;
                    pc4_nxt   = 32'h0;
                    valid_nxt = 1'b0;
                end else if (!pc_in_range) begin
                    state_nxt = HALT;
                    instr_nxt = 32'h0;
                    pc4_nxt   = 32'h0;
                    valid_nxt = 1'b0;
                end else if (!stall) begin
                    pc_nxt    = pc_plus4;
                    instr_nxt = imem_data;
                    pc4_nxt   = pc_plus4;
                    valid_nxt = 1'b1;
                    count_nxt = count_inc;
                end
            end
            HALT: begin
                // Stall is irrelevant here: IF/ID only ever carries bubbles while halted.
                instr_nxt = 32'h0;
                pc4_nxt   = 32'h0;
                valid_nxt = 1'b0;
                if (branch_taken) begin
                    pc_nxt    = target_aligned;
                    state_nxt = target_in_range ? RUN : HALT;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/branch/reset traffic against a cycle model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fetch_halt;
    logic [15:0] fetch_count;

    logic [31:0] ram [0:63];

    int n_checks;
    int n_errors;

    // Reference state: what the fetch stage should present after each edge.
    logic [31:0] m_pc;
    logic        m_halt;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [15:0] m_cnt;

    fetch_stage #(
        .ADDR_W  (8),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .fetch_halt   (fetch_halt),
        .fetch_count  (fetch_count)
    );

    assign imem_data = ram[imem_addr[7:2]];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("imem_addr", {24'h0, imem_addr}, {24'h0, m_pc[7:0]});
        check("if_id_instr", if_id_instr, m_instr);
        check("if_id_pc4", if_id_pc4, m_pc4);
        check("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
        check("fetch_halt", {31'h0, fetch_halt}, {31'h0, m_halt});
        check("fetch_count", {16'h0, fetch_count}, {16'h0, m_cnt});
    endtask

    // One clock: apply inputs, advance the model by the architectural rules, compare on the falling edge.
    task automatic cycle(input logic rst_n, input logic s, input logic b,
                         input logic [31:0] tgt, input bit chk);
        logic [31:0] word;
        logic [31:0] dest;
        reset         = rst_n;
        stall         = s;
        branch_taken  = b;
        branch_target = tgt;
        word = ram[m_pc[7:2]];
        dest = {tgt[31:2], 2'b00};
        if (!rst_n) begin
            m_pc = 32'h0; m_halt = 1'b0; m_cnt = 16'h0;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (m_halt) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            if (b) begin
                m_pc   = dest;
                m_halt = (dest >= 32'd256);
            end
        end else if (b) begin
            m_pc = dest;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (m_pc >= 32'd256) begin
            m_halt = 1'b1;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!s) begin
            m_instr = word;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        @(posedge clk);
        @(negedge clk);
        if (chk) check_all();
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        n_checks = 0;
        n_errors = 0;
        m_pc = 32'h0; m_halt = 1'b0; m_cnt = 16'h0;
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        for (int i = 0; i < 64; i++) ram[i] = $urandom;
        ram[0] = 32'hE3A00001;
        ram[1] = 32'hE3A01002;
        ram[2] = 32'hE0802001;

        // Reset held for two edges.
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 32'h40, 1'b1);
        check("rst_valid", {31'h0, if_id_valid}, 32'h0);
        check("rst_addr", {24'h0, imem_addr}, 32'h0);

        // Sequential fetch, with a two-cycle stall while PC=8.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("seq0_instr", if_id_instr, 32'hE3A00001);
        check("seq0_pc4", if_id_pc4, 32'd4);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("seq1_instr", if_id_instr, 32'hE3A01002);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            check("stall_instr", if_id_instr, 32'hE3A01002);
            check("stall_pc4", if_id_pc4, 32'd8);
            check("stall_cnt", {16'h0, fetch_count}, 32'd2);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("seq2_instr", if_id_instr, 32'hE0802001);
        check("seq2_pc4", if_id_pc4, 32'd12);
        check("seq2_cnt", {16'h0, fetch_count}, 32'd3);

        // Branch and stall in the same cycle: redirect wins, target misalignment dropped.
        cycle(1'b1, 1'b1, 1'b1, 32'h23, 1'b1);
        check("br_valid", {31'h0, if_id_valid}, 32'h0);
        check("br_addr", {24'h0, imem_addr}, 32'h20);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("br_instr", if_id_instr, ram[8]);
        check("br_pc4", if_id_pc4, 32'h24);

        // Run off the end of the RAM, then recover with a branch.
        cycle(1'b1, 1'b0, 1'b1, 32'hF8, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("end_pc4_f8", if_id_pc4, 32'hFC);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("end_pc4_fc", if_id_pc4, 32'h100);
        check("end_not_halted", {31'h0, fetch_halt}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, logic'(i[0]), 1'b0, 32'h0, 1'b1);
            check("halt_flag", {31'h0, fetch_halt}, 32'h1);
            check("halt_valid", {31'h0, if_id_valid}, 32'h0);
        end
        cycle(1'b1, 1'b0, 1'b1, 32'h1000, 1'b1);
        check("halt_oor_br", {31'h0, fetch_halt}, 32'h1);
        cycle(1'b1, 1'b0, 1'b1, 32'h10, 1'b1);
        check("unhalt", {31'h0, fetch_halt}, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("unhalt_instr", if_id_instr, ram[4]);

        // Reset mid-run beats a simultaneous branch.
        cycle(1'b1, 1'b0, 1'b1, 32'h40, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'h80, 1'b1);
        check("midrst_addr", {24'h0, imem_addr}, 32'h0);
        check("midrst_cnt", {16'h0, fetch_count}, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        s;
            logic        b;
            logic [31:0] t;
            r = ($urandom_range(0, 99) != 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 255));
            cycle(r, s, b, t, 1'b1);
        end

        // Counter saturation: loop within the RAM, branching back every 60 fetches.
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 1100; i++) begin
            for (int j = 0; j < 60; j++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            cycle(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
        end
        check_all();
        check("sat_cnt", {16'h0, fetch_count}, 32'hFFFF);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("sat_hold", {16'h0, fetch_count}, 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined CPU: holds the program counter, drives the instruction RAM address, and loads the IF/ID pipeline register consumed by the decode/control-unit stage. It applies hazard-unit stalls and branch redirects/flushes. It also stops fetching cleanly when the PC runs past the end of instruction memory.

## Interface
Parameters:
- ADDR_W, 8, instruction RAM byte-address width (256-byte RAM)
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-low; sampled on rising edge of clk
- imem_addr  output  ADDR_W  byte address to instruction RAM; equals PC[ADDR_W-1:0], combinational from PC register
- imem_data  input  32  instruction word returned combinationally by RAM for imem_addr
- stall  input  1  hazard unit: hold PC and IF/ID contents
- branch_taken  input  1  redirect from later stage: flush IF/ID, load branch_target
- branch_target  input  32  redirect address
- if_id_instr  output  32  registered instruction to decode
- if_id_pc4  output  32  registered PC+4 of that instruction
- if_id_valid  output  1  1 = if_id_instr is a real instruction; 0 = bubble
- fetch_halt  output  1  1 while in HALT state
- fetch_count  output  16  number of valid instructions loaded into IF/ID, saturating

## Operation
- State machine, two states: RUN, HALT. Reset enters RUN.
- RUN, PC in range (PC < 2^ADDR_W):
  - Normal: PC <= PC+4; IF/ID <= {imem_data, PC+4, valid=1}; fetch_count += 1, saturating at 16'hFFFF.
  - stall=1: PC, IF/ID, fetch_count hold.
  - branch_taken=1: PC <= {branch_target[31:2], 2'b00} (misaligned low bits forced to 0). IF/ID <= {32'h0, 32'h0, valid=0}. fetch_count holds.
- Priority: reset > branch_taken > stall > normal. Branch during stall flushes and redirects.
- RUN, PC out of range (PC >= 2^ADDR_W): next edge enters HALT. IF/ID loads a bubble (valid=0, instr=0, pc4=0). PC holds.
- HALT:
  - fetch_halt=1; IF/ID loads a bubble every cycle; PC holds; stall ignored.
  - branch_taken with in-range target: PC <= aligned target, return to RUN, IF/ID bubble.
  - branch_taken with out-of-range target: PC updates, stay in HALT.
- imem_addr is always PC[ADDR_W-1:0], also in HALT. The RAM read is harmless.
- PC arithmetic is 32-bit. PC+4 wraps modulo 2^32, never to 0 within ADDR_W: out-of-range detection uses the full 32-bit PC.
- RAM is read-only here. Precharge of the RAM is outside this block.

## Timing
- Reset (reset=0 at a rising edge): PC=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, fetch_halt=0, fetch_count=0, state=RUN.
- Fetch latency: the instruction at PC appears on if_id_instr one rising edge after imem_addr=PC, provided stall=0.
- First valid instruction: at the first rising edge with reset=1, it enters IF/ID (if_id_valid=1, if_id_pc4=RESET_PC+4).
- Branch penalty: exactly one bubble in IF/ID from this stage. The target instruction is in IF/ID on the second edge after branch_taken is sampled.
- Stall: a single-cycle stall delays every downstream IF/ID value by exactly one cycle. No instruction is lost or duplicated.
- Reset asserted mid-operation overrides branch/stall on that edge. Any pending state is discarded.
- HALT entry: fetch_halt rises on the edge after the PC first holds an out-of-range value.

## Test plan
- Sequential fetch: reset low 2 cycles, release; RAM words 0xE3A00001, 0xE3A01002, 0xE0802001 at 0, 4, 8 -> IF/ID shows them on edges 1–3 with pc4 = 4, 8, 12; fetch_count = 3.
- Stall: assert stall for 2 cycles while PC=8 -> IF/ID holds word@4 and pc4=8 for 2 extra cycles, then word@8; fetch_count unchanged during stall.
- Branch plus stall same cycle: branch_taken=1, branch_target=0x23, stall=1 -> next edge valid=0, PC=0x20; following edge IF/ID = word@0x20, pc4=0x24.
- Run-off-end: RESET_PC=0xF8, no branches -> valid fetches of 0xF8 and 0xFC, then PC=0x100, fetch_halt=1, valid=0 persistently; branch to 0x10 -> fetch_halt=0, word@0x10 in IF/ID two edges later.
- Reset mid-run: at PC=0x40 with branch_taken=1, drive reset=0 for one edge -> PC=RESET_PC, all outputs at reset values, branch ignored.
- Counter saturation: force 65 540 unstalled fetches with looping branch -> fetch_count stops at 0xFFFF.
